// File: rtl/conv_psum_acc_if.sv
// ---------------------------------------------------------------------------
// conv_psum_acc_if
// Control, product-stream and result-stream signals of the partial-sum
// accumulator, bundled as one interface.
//   master : the driving side (convolution datapath / test environment)
//   slave  : the accumulator itself
// Signals:
//   clear, start, bias_in         window control and bias seed
//   in_valid, in_ready, prod_in   product stream (valid/ready)
//   out_valid, out_ready, out_data result stream (valid/ready)
//   busy, ovf                     status
// ---------------------------------------------------------------------------
interface conv_psum_acc_if #(
    parameter int DATA_W = 32
);
    logic              clear;
    logic              start;
    logic [DATA_W-1:0] bias_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] prod_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              ovf;

    modport master (
        output clear, start, bias_in, in_valid, prod_in, out_ready,
        input  in_ready, out_valid, out_data, busy, ovf
    );

    modport slave (
        input  clear, start, bias_in, in_valid, prod_in, out_ready,
        output in_ready, out_valid, out_data, busy, ovf
    );
endinterface

// File: rtl/conv_psum_acc.sv
// ---------------------------------------------------------------------------
// conv_psum_acc
// Partial-sum accumulator for one convolution kernel window. A window is
// seeded with bias_in on start, accumulates exactly TERMS signed products
// from the operand mux, then offers the sum on a valid/ready output.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    conv_psum_acc_if.slave (clear, start, bias_in, in_valid/in_ready/
//          prod_in, out_valid/out_ready/out_data, busy, ovf)
//
// Build option:
//   PSUM_SAT_EN  defined   -> each add saturates, ovf is a sticky window flag
//                undefined -> adds wrap modulo 2^DATA_W, ovf stays 0
//
// State table:
//   IDLE | waiting for start, no handshakes active
//   ACC  | accepting products, in_ready=1
//   OUT  | result held on out_data, out_valid=1
// ---------------------------------------------------------------------------
module conv_psum_acc #(
    parameter int DATA_W = 32,
    parameter int TERMS  = 9,
    parameter int CNT_W  = 8
) (
    input logic           clk,
    input logic           rst_n,
    conv_psum_acc_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

    logic [1:0]        state;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] out_data_q;
    logic              ovf_q;

    logic [DATA_W-1:0] sum_wrap;
    logic [DATA_W-1:0] add_sum;
    logic              add_ovf;

    always_comb begin
        sum_wrap = acc + bus.prod_in;
        add_sum  = sum_wrap;
        add_ovf  = 1'b0;
`ifdef PSUM_SAT_EN
        // Overflow only when both operands share a sign the result lacks.
        if (!acc[DATA_W-1] && !bus.prod_in[DATA_W-1] && sum_wrap[DATA_W-1]) begin
            add_sum = {1'b0, {(DATA_W-1){1'b1}}};
            add_ovf = 1'b1;
        end else if (acc[DATA_W-1] && bus.prod_in[DATA_W-1] && !sum_wrap[DATA_W-1]) begin
            add_sum = {1'b1, {(DATA_W-1){1'b0}}};
            add_ovf = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
        end else if (bus.clear) begin
            // Abort wins in every state; a pending result is dropped.
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc   <= bus.bias_in;
                        cnt   <= '0;
                        ovf_q <= 1'b0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        acc <= add_sum;
                        cnt <= cnt + 1'b1;
                        if (add_ovf) ovf_q <= 1'b1;
                        if (cnt == LAST_CNT) begin
                            out_data_q <= add_sum;
                            state      <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and status outputs decode from state only.
    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == OUT);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_conv_psum_acc.sv
// ---------------------------------------------------------------------------
// tb_conv_psum_acc
// Directed bench for conv_psum_acc (TERMS=9, DATA_W=32). Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_conv_psum_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    conv_psum_acc_if #(.DATA_W(32)) bus ();

    conv_psum_acc #(.DATA_W(32), .TERMS(9), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] bias);
        bus.start   = 1'b1;
        bus.bias_in = bias;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.bias_in = 32'h0;
    endtask

    // Present one product after 'gap' idle cycles; returns on the falling
    // edge after it was accepted, with in_valid still high.
    task automatic feed(input logic [31:0] v, input int gap);
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.prod_in  = v;
        @(negedge clk);
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.start     = 1'b0;
        bus.bias_in   = '0;
        bus.in_valid  = 1'b0;
        bus.prod_in   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_ovf", {31'b0, bus.ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic window: bias 10 + (1..9) = 55
        do_start(32'd10);
        check("basic_busy", {31'b0, bus.busy}, 32'd1);
        check("basic_in_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 1; i <= 8; i++) feed(32'(i), 0);
        check("basic_no_early_valid", {31'b0, bus.out_valid}, 32'd0);
        feed(32'd9, 0);
        bus.in_valid = 1'b0;
        check("basic_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("basic_out_data", bus.out_data, 32'd55);
        check("basic_out_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("basic_ovf", {31'b0, bus.ovf}, 32'd0);
        @(negedge clk);
        check("basic_valid_drop", {31'b0, bus.out_valid}, 32'd0);
        check("basic_busy_drop", {31'b0, bus.busy}, 32'd0);

        // Stalls and backpressure: 9 x -3 = -27
        bus.out_ready = 1'b0;
        do_start(32'd0);
        for (int i = 0; i < 9; i++) feed(32'(-3), i % 4);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp_out_data", bus.out_data, 32'hFFFF_FFE5);
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_single_output", {31'b0, bus.out_valid}, 32'd0);
        check("bp_idle", {31'b0, bus.busy}, 32'd0);

        // Overflow
        do_start(32'h7FFF_FFF0);
        feed(32'h20, 0);
        for (int i = 0; i < 8; i++) feed(32'h0, 0);
        bus.in_valid = 1'b0;
        check("ovf_out_valid", {31'b0, bus.out_valid}, 32'd1);
`ifdef PSUM_SAT_EN
        check("ovf_out_data", bus.out_data, 32'h7FFF_FFFF);
        check("ovf_flag", {31'b0, bus.ovf}, 32'd1);
`else
        check("ovf_out_data", bus.out_data, 32'h8000_0010);
        check("ovf_flag", {31'b0, bus.ovf}, 32'd0);
`endif
        @(negedge clk);

        // Clear mid-window
        do_start(32'd5);
        for (int i = 0; i < 4; i++) feed(32'd1, 0);
        bus.in_valid = 1'b0;
        bus.clear    = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clr_busy", {31'b0, bus.busy}, 32'd0);
        check("clr_in_ready", {31'b0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("clr_no_valid", {31'b0, bus.out_valid}, 32'd0);
            @(negedge clk);
        end
        do_start(32'd1);
        for (int i = 0; i < 9; i++) feed(32'd2, 0);
        bus.in_valid = 1'b0;
        check("clr_new_valid", {31'b0, bus.out_valid}, 32'd1);
        check("clr_new_data", bus.out_data, 32'd19);
        @(negedge clk);

        // Reset mid-window
        do_start(32'd7);
        for (int i = 0; i < 3; i++) feed(32'd1, 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstw_busy", {31'b0, bus.busy}, 32'd0);
        check("rstw_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rstw_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rstw_out_data", bus.out_data, 32'd0);
        check("rstw_ovf", {31'b0, bus.ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstw_stays_idle", {31'b0, bus.busy}, 32'd0);

        // Ignored start in ACC and OUT
        bus.out_ready = 1'b0;
        do_start(32'd10);
        for (int i = 1; i <= 3; i++) feed(32'(i), 0);
        bus.in_valid = 1'b0;
        do_start(32'd1000);
        for (int i = 4; i <= 9; i++) feed(32'(i), 0);
        bus.in_valid = 1'b0;
        check("ign_acc_data", bus.out_data, 32'd55);
        do_start(32'd1000);
        check("ign_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("ign_out_data", bus.out_data, 32'd55);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("ign_idle", {31'b0, bus.busy}, 32'd0);

        // clear + start together in IDLE
        bus.clear = 1'b1;
        do_start(32'd3);
        bus.clear = 1'b0;
        check("clrstart_busy", {31'b0, bus.busy}, 32'd0);
        check("clrstart_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(negedge clk);

        // Back-to-back windows: 55 then 45
        do_start(32'd10);
        for (int i = 1; i <= 9; i++) feed(32'(i), 0);
        bus.in_valid = 1'b0;
        check("b2b_first_valid", {31'b0, bus.out_valid}, 32'd1);
        check("b2b_first_data", bus.out_data, 32'd55);
        @(negedge clk);
        do_start(32'd0);
        check("b2b_second_in_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 1; i <= 9; i++) feed(32'(i), 0);
        bus.in_valid = 1'b0;
        check("b2b_second_valid", {31'b0, bus.out_valid}, 32'd1);
        check("b2b_second_data", bus.out_data, 32'd45);
        @(negedge clk);
        check("b2b_done", {31'b0, bus.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
